// File: rtl/key_pulser_if.sv
// Button bundle between the KEY pins and the debounce front end.
// master drives the raw active-low keys; slave returns the cleaned events.
interface key_pulser_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] key_n;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] release_evt;
  logic [WIDTH-1:0] repeat_evt;

  modport master (
    output key_n,
    input  level,
    input  press,
    input  release_evt,
    input  repeat_evt
  );

  modport slave (
    input  key_n,
    output level,
    output press,
    output release_evt,
    output repeat_evt
  );
endinterface

// File: rtl/key_pulser.sv
// Push-button front end: per key a 2-flop synchroniser, a debounce FSM with
// counter, a debounced level, registered press/release pulses and an optional
// hold-to-repeat pulse. Channels are fully independent.
module key_pulser #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic         clk,
  input logic         rst,
  key_pulser_if.slave bus
);

  localparam int MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P  = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] D_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] P_LAST  = CW'(REPEAT_PERIOD - 1);
  // hold counts up to R_LAST, fires the first repeat, then parks at R_ARMED
  // so it can never wrap back into a spurious first repeat.
  localparam logic [CW-1:0] R_LAST  = CW'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [CW-1:0] R_ARMED = CW'(REPEAT_DELAY);

  typedef enum logic [1:0] {UP, DB_DN, DOWN, DB_UP} state_t;

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] raw;

  state_t [WIDTH-1:0]          state_q, state_d;
  logic   [WIDTH-1:0][CW-1:0]  cnt_q, cnt_d;
  logic   [WIDTH-1:0][CW-1:0]  hold_q, hold_d;
  logic   [WIDTH-1:0][CW-1:0]  per_q, per_d;
  logic   [WIDTH-1:0]          level_q, level_d;
  logic   [WIDTH-1:0]          press_q, press_d;
  logic   [WIDTH-1:0]          release_q, release_d;
  logic   [WIDTH-1:0]          repeat_q, repeat_d;

  // Two-flop synchroniser; resets to the released (high) level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= bus.key_n;
      sync2 <= sync1;
    end
  end

  assign raw = ~sync2;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) state_q[i] <= UP;
      cnt_q     <= '0;
      hold_q    <= '0;
      per_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      per_q     <= per_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  // Per-channel next state, counter updates and pulse decisions
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    per_d     = per_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (state_q[i])
        UP: begin
          level_d[i] = 1'b0;
          if (raw[i]) begin
            state_d[i] = DB_DN;
            cnt_d[i]   = '0;
          end
        end
        DB_DN: begin
          if (!raw[i]) begin
            state_d[i] = UP;
          end else if (cnt_q[i] == D_LAST) begin
            state_d[i] = DOWN;
            press_d[i] = 1'b1;
            level_d[i] = 1'b1;
            hold_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        DOWN: begin
          if (!raw[i]) begin
            state_d[i] = DB_UP;
            cnt_d[i]   = '0;
          end else if (REPEAT_DELAY != 0) begin
            if (hold_q[i] == R_ARMED) begin
              if (per_q[i] == P_LAST) begin
                repeat_d[i] = 1'b1;
                per_d[i]    = '0;
              end else begin
                per_d[i] = per_q[i] + 1'b1;
              end
            end else if (hold_q[i] == R_LAST) begin
              repeat_d[i] = 1'b1;
              hold_d[i]   = R_ARMED;
              per_d[i]    = '0;
            end else begin
              hold_d[i] = hold_q[i] + 1'b1;
            end
          end
        end
        DB_UP: begin
          // A glitch back to pressed resumes the hold timing where it paused
          if (raw[i]) begin
            state_d[i] = DOWN;
          end else if (cnt_q[i] == D_LAST) begin
            state_d[i]   = UP;
            release_d[i] = 1'b1;
            level_d[i]   = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.level       = level_q;
  assign bus.press       = press_q;
  assign bus.release_evt = release_q;
  assign bus.repeat_evt  = repeat_q;

endmodule
